counter_seq_ctrl: RTL

Sequencing controller for the lab counter datapath. It turns the raw active-low board buttons into clean single-cycle commands: run/pause, single step and load-from-switches. It drives the counter's increment and load strobes from a small FSM and a tick divider. It sits between the board pins (key_i, sw_i) and the counter, and is clocked from clk100_i.

---
 rtl/counter_seq_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - button debounce and run/step/load sequencer for the lab counter.
// Optional step auto-repeat in PAUSE is enabled by defining STEP_REPEAT_EN.
module counter_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8,
    parameter int REPEAT_DELAY    = 16,
    parameter int SW_W            = 10
) (
    input  logic            clk100_i,
    input  logic            rstn_i,
    input  logic [2:0]      key_i,
    input  logic [SW_W-1:0] sw_i,
    output logic            cnt_inc_o,
    output logic            cnt_load_o,
    output logic [SW_W-1:0] cnt_load_val_o,
    output logic            run_o,
    output logic [1:0]      state_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_DIV - 1);

    if (DEBOUNCE_CYCLES < 1 || TICK_DIV < 2 || REPEAT_DELAY < 1) begin : g_bad_param
        $error("counter_seq_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        sync1;
    logic [2:0]        sync2;
    logic [2:0]        deb;
    logic [DB_W-1:0]   db_cnt [3];
    logic [2:0]        press;
    logic              ev_load;
    logic              ev_run;
    logic              ev_step;
    logic [TK_W-1:0]   tick;

`ifdef STEP_REPEAT_EN
    localparam int RP_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    logic [RP_W-1:0]   rpt_cnt;
    logic              rpt_on;
`endif

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            deb   <= 3'b111;
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_MAX) begin
                    deb[k]    <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    // The press is flagged in the same cycle the debounced level falls, so the FSM reacts on that edge.
    always_comb begin
        press = 3'b000;
        for (int k = 0; k < 3; k++)
            press[k] = deb[k] & ~sync2[k] & (db_cnt[k] == DB_MAX);
        ev_load = press[2];
        ev_run  = press[0] & ~press[2];
        ev_step = press[1] & ~press[0] & ~press[2];
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= S_IDLE;
            tick           <= '0;
            cnt_inc_o      <= 1'b0;
            cnt_load_o     <= 1'b0;
            cnt_load_val_o <= '0;
            run_o          <= 1'b0;
`ifdef STEP_REPEAT_EN
            rpt_cnt        <= '0;
            rpt_on         <= 1'b0;
`endif
        end else begin
            cnt_inc_o  <= 1'b0;
            cnt_load_o <= 1'b0;
`ifdef STEP_REPEAT_EN
            if (state != S_PAUSE) begin
                rpt_cnt <= '0;
                rpt_on  <= 1'b0;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (ev_load) begin
                        state          <= S_LOAD;
                        cnt_load_o     <= 1'b1;
                        cnt_load_val_o <= sw_i;
                    end else if (ev_run) begin
                        state <= S_RUN;
                        tick  <= '0;
                        run_o <= 1'b1;
                    end else if (ev_step) begin
                        state     <= S_PAUSE;
                        cnt_inc_o <= 1'b1;
                    end
                end
                // A tick wrap coinciding with a run/load press is dropped along with the transition.
                S_RUN: begin
                    if (ev_load) begin
                        state          <= S_LOAD;
                        cnt_load_o     <= 1'b1;
                        cnt_load_val_o <= sw_i;
                        run_o          <= 1'b0;
                    end else if (ev_run) begin
                        state <= S_PAUSE;
                        run_o <= 1'b0;
                    end else if (tick == TK_MAX) begin
                        tick      <= '0;
                        cnt_inc_o <= 1'b1;
                    end else begin
                        tick <= tick + TK_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (ev_load) begin
                        state          <= S_LOAD;
                        cnt_load_o     <= 1'b1;
                        cnt_load_val_o <= sw_i;
                    end else if (ev_run) begin
                        state <= S_RUN;
                        tick  <= '0;
                        run_o <= 1'b1;
                    end else if (ev_step) begin
                        cnt_inc_o <= 1'b1;
`ifdef STEP_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_on    <= 1'b0;
                    end else if (deb[1]) begin
                        rpt_cnt <= '0;
                        rpt_on  <= 1'b0;
                    end else if (!rpt_on) begin
                        if (rpt_cnt == RP_W'(REPEAT_DELAY - 1)) begin
                            rpt_on <= 1'b1;
                            tick   <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RP_W'(1);
                        end
                    end else if (tick == TK_MAX) begin
                        tick      <= '0;
                        cnt_inc_o <= 1'b1;
                    end else begin
                        tick <= tick + TK_W'(1);
`endif
                    end
                end
                S_LOAD: begin
                    state <= S_PAUSE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
